// File: rtl/cb_param_crc_pkg.sv
// Shared constants, state encoding and helper functions for the connection box
// and other fabric blocks that reuse its serial CRC-8 frame check.
package cb_pkg;

    localparam int CRC_W = 8;
    localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;

    // Program shift-register fill level, decoded from the bit counter.
    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_LOADING,
        ST_FULL,
        ST_OVER
    } cb_state_e;

    function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc,
                                                   input logic             bit_in);
        logic fb;
        fb = crc[CRC_W-1] ^ bit_in;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : {CRC_W{1'b0}});
    endfunction

    // Selector code 0 means "drive 0", so one extra code beyond the input bits.
    function automatic int sel_width(input int n_in, input int w);
        return $clog2(n_in * w + 1);
    endfunction

endpackage

// File: rtl/cb_param_crc_if.sv
// Program port and data channels of the connection box, bundled so the
// configuration master and the box share one typed connection.
interface cb_param_crc_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int W     = 4
);

    logic                  prog_in;
    logic                  prog_en;
    logic                  prog_commit;
    logic                  prog_rb;
    logic                  prog_out;
    logic [N_IN*W-1:0]     in_flat;
    logic [N_OUT*W-1:0]    out_flat;
    logic                  cfg_valid;
    logic                  cfg_err;

    modport master (
        output prog_in,
        output prog_en,
        output prog_commit,
        output prog_rb,
        output in_flat,
        input  prog_out,
        input  out_flat,
        input  cfg_valid,
        input  cfg_err
    );

    modport slave (
        input  prog_in,
        input  prog_en,
        input  prog_commit,
        input  prog_rb,
        input  in_flat,
        output prog_out,
        output out_flat,
        output cfg_valid,
        output cfg_err
    );

endinterface

// File: rtl/cb_crc8_serial.sv
// Bit-serial CRC-8 remainder register; a good frame (payload then trailer,
// MSB first) leaves the remainder at zero.
module cb_crc8_serial
    import cb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_d;

    // Clear takes priority so a caller can restart a frame on any cycle.
    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = '0;
        end else if (en) begin
            crc_d = crc8_step(crc_q, bit_in);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/cb_param_crc.sv
// Parametrised connection box: serial CRC-checked program frame, shadow/active
// double buffer with readback, and a registered per-output-bit selector mux.
module cb_param_crc
    import cb_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int W     = 4
) (
    input  logic          prog_clk,
    input  logic          rst,
    cb_param_crc_if.slave bus
);

    localparam int SEL_W      = sel_width(N_IN, W);
    localparam int IN_BITS    = N_IN * W;
    localparam int OUT_BITS   = N_OUT * W;
    localparam int CFG_BITS   = OUT_BITS * SEL_W;
    localparam int FRAME_BITS = CFG_BITS + CRC_W;
    localparam int CNT_W      = $clog2(FRAME_BITS + 2);
    localparam int EXT_W      = 1 << SEL_W;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    logic [FRAME_BITS-1:0] sreg_q,      sreg_d;
    logic [FRAME_BITS-1:0] active_q,    active_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic                  cfg_valid_q, cfg_valid_d;
    logic                  cfg_err_q,   cfg_err_d;
    logic [OUT_BITS-1:0]   out_flat_q,  out_flat_d;

    logic [CRC_W-1:0]      crc;
    logic                  shift_en;
    logic                  commit_acc;
    logic                  rb_acc;
    logic                  frame_ok;
    cb_state_e             state;
    logic [EXT_W-1:0]      in_ext;

    // Shifting wins over both pulses, and commit wins over readback.
    assign shift_en   = bus.prog_en;
    assign commit_acc = !bus.prog_en && bus.prog_commit;
    assign rb_acc     = !bus.prog_en && !bus.prog_commit && bus.prog_rb;

    cb_crc8_serial u_crc (
        .clk    (prog_clk),
        .rst    (rst),
        .clear  (commit_acc || rb_acc),
        .en     (shift_en),
        .bit_in (bus.prog_in),
        .crc    (crc)
    );

    always_comb begin
        state = ST_LOADING;
        if (cnt_q == '0) begin
            state = ST_EMPTY;
        end else if (cnt_q == CNT_FULL) begin
            state = ST_FULL;
        end else if (cnt_q > CNT_FULL) begin
            state = ST_OVER;
        end
    end

    assign frame_ok = (state == ST_FULL) && (crc == '0);

    // A failed commit leaves active and cfg_valid alone but still restarts the frame.
    always_comb begin
        sreg_d      = sreg_q;
        active_d    = active_q;
        cnt_d       = cnt_q;
        cfg_valid_d = cfg_valid_q;
        cfg_err_d   = cfg_err_q;
        if (shift_en) begin
            sreg_d = {bus.prog_in, sreg_q[FRAME_BITS-1:1]};
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (commit_acc) begin
            cnt_d = '0;
            if (frame_ok) begin
                active_d    = sreg_q;
                cfg_valid_d = 1'b1;
                cfg_err_d   = 1'b0;
            end else begin
                cfg_err_d   = 1'b1;
            end
        end else if (rb_acc) begin
            sreg_d = active_q;
            cnt_d  = '0;
        end
    end

    // Code 0 and every code above IN_BITS land on the zero-filled ends of this vector.
    always_comb begin
        in_ext            = '0;
        in_ext[IN_BITS:1] = bus.in_flat;
    end

    for (genvar j = 0; j < OUT_BITS; j++) begin : g_route
        logic [SEL_W-1:0] sel;
        assign sel           = active_q[j*SEL_W +: SEL_W];
        assign out_flat_d[j] = in_ext[sel];
    end

    always_ff @(posedge prog_clk or posedge rst) begin
        if (rst) begin
            sreg_q      <= '0;
            active_q    <= '0;
            cnt_q       <= '0;
            cfg_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            out_flat_q  <= '0;
        end else begin
            sreg_q      <= sreg_d;
            active_q    <= active_d;
            cnt_q       <= cnt_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_err_q   <= cfg_err_d;
            out_flat_q  <= out_flat_d;
        end
    end

    assign bus.prog_out  = sreg_q[0];
    assign bus.out_flat  = out_flat_q;
    assign bus.cfg_valid = cfg_valid_q;
    assign bus.cfg_err   = cfg_err_q;

endmodule
